// File: rtl/shutdown_sense_ctrl_if.sv
// Handshake bundle between the hardware manager, the board shutdown pins and
// the shutdown_sense_ctrl responder.
interface shutdown_sense_ctrl_if;
    logic       shutdown_force;
    logic       n_shutdown_rst;
    logic [7:0] sense_pin;
    logic       n_shutdown_force_pin;
    logic       n_shutdown_rst_pin;
    logic       shutdown_sense;
    logic [2:0] sense_num;
    logic [7:0] sense_latched;
    logic       armed;

    modport master (
        output shutdown_force, n_shutdown_rst, sense_pin,
        input  n_shutdown_force_pin, n_shutdown_rst_pin, shutdown_sense,
               sense_num, sense_latched, armed
    );

    modport slave (
        input  shutdown_force, n_shutdown_rst, sense_pin,
        output n_shutdown_force_pin, n_shutdown_rst_pin, shutdown_sense,
               sense_num, sense_latched, armed
    );
endinterface

// File: rtl/shutdown_sense_ctrl.sv
// Board-side shutdown responder: stretches the manager's reset request into a
// board reset pulse, settles, then debounces eight sense pins and latches the first fault.
module shutdown_sense_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned RST_PULSE_CYCLES = 250,
    parameter int unsigned SETTLE_CYCLES    = 2500
) (
    input logic                  clk,
    input logic                  rst,
    shutdown_sense_ctrl_if.slave bus
);

    localparam logic [2:0] FORCED    = 3'd0;
    localparam logic [2:0] RESETTING = 3'd1;
    localparam logic [2:0] SETTLE    = 3'd2;
    localparam logic [2:0] ARMED     = 3'd3;
    localparam logic [2:0] TRIPPED   = 3'd4;

    localparam logic [31:0] DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] PULSE_LAST  = 32'(RST_PULSE_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    logic [2:0]  state;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  filtered;
    logic [31:0] deb_cnt [8];
    logic [31:0] pulse_cnt;
    logic [31:0] settle_cnt;
    logic        force_pin_n;
    logic        rst_pin_n;
    logic        sense_q;
    logic [2:0]  num_q;
    logic [7:0]  latched_q;
    logic        armed_q;

    function automatic logic [2:0] lowest_set(input logic [7:0] bits);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) lowest_set = 3'(i);
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.sense_pin;
            sync2 <= sync1;
        end
    end

    // Any sample matching the filtered value restarts that channel's count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtered <= '0;
            for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == filtered[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DEB_LAST) begin
                    filtered[i] <= sync2[i];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Forcing wins over everything, including a trip detected on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FORCED;
            pulse_cnt   <= '0;
            settle_cnt  <= '0;
            force_pin_n <= 1'b0;
            rst_pin_n   <= 1'b1;
            sense_q     <= 1'b0;
            num_q       <= '0;
            latched_q   <= '0;
            armed_q     <= 1'b0;
        end else if (bus.shutdown_force) begin
            state       <= FORCED;
            pulse_cnt   <= '0;
            settle_cnt  <= '0;
            force_pin_n <= 1'b0;
            rst_pin_n   <= 1'b1;
            sense_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            case (state)
                FORCED: begin
                    if (!bus.n_shutdown_rst) begin
                        state       <= RESETTING;
                        pulse_cnt   <= PULSE_LAST;
                        force_pin_n <= 1'b1;
                        rst_pin_n   <= 1'b0;
                        sense_q     <= 1'b0;
                        num_q       <= '0;
                        latched_q   <= '0;
                    end
                end
                RESETTING: begin
                    if (pulse_cnt != '0) begin
                        pulse_cnt <= pulse_cnt - 32'd1;
                    end else if (bus.n_shutdown_rst) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LAST;
                        rst_pin_n  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 32'd1;
                    end else begin
                        state   <= ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (|filtered) begin
                        state       <= TRIPPED;
                        armed_q     <= 1'b0;
                        sense_q     <= 1'b1;
                        latched_q   <= filtered;
                        num_q       <= lowest_set(filtered);
                        force_pin_n <= 1'b0;
                    end
                end
                TRIPPED: begin
                end
                default: begin
                    state <= FORCED;
                end
            endcase
        end
    end

    assign bus.n_shutdown_force_pin = force_pin_n;
    assign bus.n_shutdown_rst_pin   = rst_pin_n;
    assign bus.shutdown_sense       = sense_q;
    assign bus.sense_num            = num_q;
    assign bus.sense_latched        = latched_q;
    assign bus.armed                = armed_q;

endmodule

// File: tb/tb_shutdown_sense_ctrl.sv
// Scoreboard bench for shutdown_sense_ctrl: every output change is matched,
// in order and by cycle, against hand-computed expected snapshots.
module tb_shutdown_sense_ctrl;

    localparam int D  = 4;
    localparam int RP = 8;
    localparam int SC = 16;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   failures;

    string       tag_q[$];
    int          cyc_q[$];
    logic [14:0] outs_q[$];

    shutdown_sense_ctrl_if sif();

    shutdown_sense_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .RST_PULSE_CYCLES(RP),
        .SETTLE_CYCLES   (SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: {force_pin_n, rst_pin_n, sense, num[2:0], latched[7:0], armed}
    function automatic logic [14:0] pack(input logic fp, input logic rp, input logic ss,
                                         input logic [2:0] n, input logic [7:0] l, input logic a);
        return {fp, rp, ss, n, l, a};
    endfunction

    task automatic expectAt(input string tag, input int c, input logic [14:0] o);
        tag_q.push_back(tag);
        cyc_q.push_back(c);
        outs_q.push_back(o);
    endtask

    task automatic applyStimulus(input logic sf, input logic nrst, input logic [7:0] sense,
                                 input int cycles);
        sif.shutdown_force = sf;
        sif.n_shutdown_rst = nrst;
        sif.sense_pin      = sense;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input logic [14:0] actual);
        string       tag;
        int          c;
        logic [14:0] o;
        tests++;
        if (tag_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_change: got outs=%h at cycle %0d, required no change",
                     actual, cyc);
        end else begin
            tag = tag_q.pop_front();
            c   = cyc_q.pop_front();
            o   = outs_q.pop_front();
            if (actual !== o || (c >= 0 && c != cyc)) begin
                failures++;
                $display("[TB] FAIL %s: got outs=%h cycle=%0d, required outs=%h cycle=%0d",
                         tag, actual, cyc, o, c);
            end
        end
    endtask

    // Monitor: any change of the output bundle is one presented response.
    initial begin
        logic [14:0] prev;
        logic [14:0] cur;
        prev = 'x;
        forever begin
            @(negedge clk);
            cur = pack(sif.n_shutdown_force_pin, sif.n_shutdown_rst_pin, sif.shutdown_sense,
                       sif.sense_num, sif.sense_latched, sif.armed);
            if (cur !== prev) begin
                checkOutput(cur);
                prev = cur;
            end
        end
    end

    task automatic startBoard(input logic [7:0] settle_sense, input logic [2:0] exp_num);
        int t0;
        applyStimulus(1'b0, 1'b1, 8'h00, 2);
        t0 = cyc;
        expectAt("pulse_start", t0 + 1, pack(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        expectAt("pulse_end", t0 + 1 + RP, pack(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        expectAt("armed", t0 + 1 + RP + SC, pack(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
        if (settle_sense != 8'h00)
            expectAt("settle_trip", t0 + 2 + RP + SC,
                     pack(1'b0, 1'b1, 1'b1, exp_num, settle_sense, 1'b0));
        applyStimulus(1'b0, 1'b0, 8'h00, 1);
        applyStimulus(1'b0, 1'b1, 8'h00, RP + 1);
        applyStimulus(1'b0, 1'b1, settle_sense, SC + 2);
    endtask

    task automatic tripOn(input logic [7:0] sense, input logic [2:0] exp_num);
        expectAt("trip", cyc + D + 3, pack(1'b0, 1'b1, 1'b1, exp_num, sense, 1'b0));
        applyStimulus(1'b0, 1'b1, sense, D + 5);
    endtask

    task automatic forceOff(input logic [2:0] exp_num, input logic [7:0] exp_lat);
        expectAt("forced", cyc + 1, pack(1'b0, 1'b1, 1'b0, exp_num, exp_lat, 1'b0));
        applyStimulus(1'b1, 1'b1, 8'h00, 2);
    endtask

    initial begin
        int t0;
        tests    = 0;
        failures = 0;
        rst      = 1'b1;
        expectAt("reset_state", -1, pack(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        applyStimulus(1'b1, 1'b1, 8'h00, 3);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h00, 2);

        // Startup, glitch rejection, then a steady fault on board 3
        startBoard(8'h00, 3'd0);
        applyStimulus(1'b0, 1'b1, 8'h08, 3);
        applyStimulus(1'b0, 1'b1, 8'h00, 6);
        tripOn(8'h08, 3'd3);
        forceOff(3'd3, 8'h08);

        // Two boards at once, then force keeps the latched fields
        startBoard(8'h00, 3'd0);
        tripOn(8'h24, 3'd2);
        forceOff(3'd2, 8'h24);

        // Fault raised during settle only trips once armed
        startBoard(8'h80, 3'd7);
        forceOff(3'd7, 8'h80);

        // Force during the reset pulse abandons it
        applyStimulus(1'b0, 1'b1, 8'h00, 2);
        t0 = cyc;
        expectAt("abort_resetting", t0 + 1, pack(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        expectAt("abort_forced", t0 + 4, pack(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        applyStimulus(1'b0, 1'b0, 8'h00, 1);
        applyStimulus(1'b0, 1'b1, 8'h00, 2);
        applyStimulus(1'b1, 1'b1, 8'h00, 3);

        // Async reset while tripped on board 5
        startBoard(8'h00, 3'd0);
        tripOn(8'h20, 3'd5);
        applyStimulus(1'b0, 1'b1, 8'h20, 2);
        expectAt("async_reset", cyc, pack(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h20, 2);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h00, 4);

        tests++;
        if (tag_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_response: %0d expected changes never seen (first %s), required 0",
                     tag_q.size(), tag_q[0]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
